// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit for the E stage; owns HI/LO and reports
// Start/Busy so the hazard controller can stall MDU-class instructions in D.
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  MDOp,
   input  logic        Req,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Start,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;

   state_t      state, state_next;
   logic [3:0]  count, count_next;
   logic [31:0] rhi, rhi_next, rlo, rlo_next;
   logic        rwrite, rwrite_next;
   logic [31:0] hi_next, lo_next;

   logic        is_mult, is_div, is_sdiv, accept;
   logic [63:0] prod_s, prod_u;
   logic [31:0] dvd_mag, dvs_mag, q_mag, r_mag, quot, rem;

   assign is_mult = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
   assign is_div  = (MDOp == OP_DIV)  || (MDOp == OP_DIVU);
   assign is_sdiv = (MDOp == OP_DIV);
   assign accept  = (state == IDLE) && !Req;
   assign Start   = accept && (is_mult || is_div);
   assign Busy    = (state == RUN);

   assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign prod_u = {32'd0, A} * {32'd0, B};

   // Signed division runs on magnitudes through one shared unsigned divider,
   // which also yields 0x80000000 for the 0x80000000 / -1 overflow case.
   assign dvd_mag = (is_sdiv && A[31]) ? (~A + 32'd1) : A;
   assign dvs_mag = (is_sdiv && B[31]) ? (~B + 32'd1) : B;
   assign q_mag   = (dvs_mag == 32'd0) ? 32'd0 : dvd_mag / dvs_mag;
   assign r_mag   = (dvs_mag == 32'd0) ? 32'd0 : dvd_mag % dvs_mag;
   assign quot    = (is_sdiv && (A[31] ^ B[31])) ? (~q_mag + 32'd1) : q_mag;
   assign rem     = (is_sdiv && A[31]) ? (~r_mag + 32'd1) : r_mag;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_next  = state;
      count_next  = count;
      rhi_next    = rhi;
      rlo_next    = rlo;
      rwrite_next = rwrite;
      hi_next     = HI;
      lo_next     = LO;
      case (state)
         IDLE: begin
            if (Start) begin
               state_next  = RUN;
               count_next  = is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
               rwrite_next = is_mult || (B != 32'd0);
               case (MDOp)
                  OP_MULT:  {rhi_next, rlo_next} = prod_s;
                  OP_MULTU: {rhi_next, rlo_next} = prod_u;
                  default:  {rhi_next, rlo_next} = {rem, quot};
               endcase
            end else if (accept && MDOp == OP_MTHI) begin
               hi_next = A;
            end else if (accept && MDOp == OP_MTLO) begin
               lo_next = A;
            end
         end
         RUN: begin
            count_next = count - 4'd1;
            if (count == 4'd1) begin
               state_next  = IDLE;
               rwrite_next = 1'b0;
               if (rwrite) begin
                  hi_next = rhi;
                  lo_next = rlo;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         count  <= 4'd0;
         rhi    <= 32'd0;
         rlo    <= 32'd0;
         rwrite <= 1'b0;
         HI     <= 32'd0;
         LO     <= 32'd0;
      end else begin
         state  <= state_next;
         count  <= count_next;
         rhi    <= rhi_next;
         rlo    <= rlo_next;
         rwrite <= rwrite_next;
         HI     <= hi_next;
         LO     <= lo_next;
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vectors plus randomized
// operations compared against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk;
   logic        reset;
   logic [3:0]  MDOp;
   logic        Req;
   logic [31:0] A, B;
   logic        Start, Busy;
   logic [31:0] HI, LO;

   int checks = 0;
   int errors = 0;
   logic [31:0] hi_m, lo_m;

   mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .MDOp(MDOp), .Req(Req), .A(A), .B(B),
      .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {HI,LO} after an op, from ordinary 64-bit arithmetic.
   function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
      longint sa, sb, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         4'd1: res = 64'(sa * sb);
         4'd2: res = 64'(a) * 64'(b);
         4'd3: begin
            if (b == 0) res = {hi, lo};
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         4'd4: res = (b == 0) ? {hi, lo} : {a % b, a / b};
         default: res = {hi, lo};
      endcase
      return res;
   endfunction

   // Issue an op at the negedge; ends on the negedge where Busy has dropped.
   // noisy=1 drives random ignored ops/Req while busy, else a steady mtlo 0x55.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit noisy, input string name);
      logic [63:0] exp;
      int n, busy_cycles;
      exp = model(op, a, b, hi_m, lo_m);
      n = (op <= 4'd2) ? MULT_N : DIV_N;
      MDOp = op; A = a; B = b; Req = 1'b0;
      #1;
      checks++;
      if (Start !== 1'b1) begin
         errors++;
         $display("FAIL %s start: got %b want 1", name, Start);
      end
      @(posedge clk); #1;
      busy_cycles = 0;
      for (int i = 0; i < 40; i++) begin
         if (noisy) begin
            MDOp = 4'($urandom_range(0, 15)); A = $urandom; B = $urandom;
            Req = 1'($urandom_range(0, 1));
         end else begin
            MDOp = 4'd6; A = 32'h55; Req = 1'b0;
         end
         @(negedge clk);
         if (Busy !== 1'b1) break;
         busy_cycles++;
         checks++;
         if (Start !== 1'b0) begin
            errors++;
            $display("FAIL %s start_while_busy: got %b want 0", name, Start);
         end
      end
      MDOp = 4'd0; Req = 1'b0;
      checks++;
      if (busy_cycles != n) begin
         errors++;
         $display("FAIL %s busy_len: got %0d want %0d", name, busy_cycles, n);
      end
      checks++;
      if (HI !== exp[63:32] || LO !== exp[31:0]) begin
         errors++;
         $display("FAIL %s result: got HI=%h LO=%h want HI=%h LO=%h",
                  name, HI, LO, exp[63:32], exp[31:0]);
      end
      hi_m = exp[63:32];
      lo_m = exp[31:0];
   endtask

   // mthi/mtlo from the negedge; checks Start/Busy stay low.
   task automatic move_op(input logic [3:0] op, input logic [31:0] a);
      MDOp = op; A = a; Req = 1'b0;
      #1;
      checks++;
      if (Start !== 1'b0) begin
         errors++;
         $display("FAIL move start: got %b want 0", Start);
      end
      @(posedge clk); #1;
      MDOp = 4'd0;
      checks++;
      if (Busy !== 1'b0) begin
         errors++;
         $display("FAIL move busy: got %b want 0", Busy);
      end
      if (op == 4'd5) hi_m = a; else lo_m = a;
      @(negedge clk);
   endtask

   task automatic check_hilo(input string name);
      checks++;
      if (HI !== hi_m || LO !== lo_m) begin
         errors++;
         $display("FAIL %s hilo: got HI=%h LO=%h want HI=%h LO=%h", name, HI, LO, hi_m, lo_m);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; MDOp = 4'd0; Req = 1'b0; A = 32'd0; B = 32'd0;
      repeat (2) @(negedge clk);
      hi_m = 32'd0; lo_m = 32'd0;
      checks++;
      if (Busy !== 1'b0 || Start !== 1'b0) begin
         errors++;
         $display("FAIL reset flags: got Busy=%b Start=%b want 0 0", Busy, Start);
      end
      check_hilo("reset");
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mult();
      run_op(4'd1, 32'hFFFFFFFE, 32'd3, 1'b1, "mult_neg");
      checks++;
      if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin
         errors++;
         $display("FAIL mult_const: got HI=%h LO=%h want ffffffff fffffffa", HI, LO);
      end
      run_op(4'd2, 32'hFFFFFFFE, 32'd3, 1'b1, "multu");
      checks++;
      if (HI !== 32'h00000002 || LO !== 32'hFFFFFFFA) begin
         errors++;
         $display("FAIL multu_const: got HI=%h LO=%h want 00000002 fffffffa", HI, LO);
      end
   endtask

   task automatic test_div();
      run_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1, "div_neg");
      checks++;
      if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
         errors++;
         $display("FAIL div_const: got HI=%h LO=%h want ffffffff fffffffd", HI, LO);
      end
      run_op(4'd4, 32'd7, 32'd2, 1'b1, "divu");
      run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, "div_ovf");
      checks++;
      if (HI !== 32'd0 || LO !== 32'h80000000) begin
         errors++;
         $display("FAIL div_ovf_const: got HI=%h LO=%h want 00000000 80000000", HI, LO);
      end
      run_op(4'd3, 32'd7, 32'hFFFFFFFE, 1'b1, "div_negdivisor");
   endtask

   task automatic test_div_zero();
      move_op(4'd5, 32'h11);
      move_op(4'd6, 32'h22);
      run_op(4'd3, 32'd5, 32'd0, 1'b1, "div_zero");
      run_op(4'd4, 32'hFFFF0000, 32'd0, 1'b1, "divu_zero");
      checks++;
      if (HI !== 32'h11 || LO !== 32'h22) begin
         errors++;
         $display("FAIL div_zero_keep: got HI=%h LO=%h want 11 22", HI, LO);
      end
   endtask

   task automatic test_move();
      move_op(4'd5, 32'hDEADBEEF);
      move_op(4'd6, 32'h1234);
      check_hilo("mthi_mtlo");
   endtask

   task automatic test_ignored();
      run_op(4'd1, 32'd1000, 32'd77, 1'b0, "mult_vs_mtlo");
      checks++;
      if (LO !== 32'd77000) begin
         errors++;
         $display("FAIL mtlo_ignored: got LO=%h want %h", LO, 32'd77000);
      end
      MDOp = 4'd1; Req = 1'b1; A = $urandom; B = $urandom;
      #1;
      checks++;
      if (Start !== 1'b0) begin
         errors++;
         $display("FAIL req_start: got %b want 0", Start);
      end
      @(posedge clk); #1;
      checks++;
      if (Busy !== 1'b0) begin
         errors++;
         $display("FAIL req_busy: got %b want 0", Busy);
      end
      MDOp = 4'd5;
      @(negedge clk);
      check_hilo("req_ignored");
      MDOp = 4'd0; Req = 1'b0;
   endtask

   task automatic test_back_to_back();
      run_op(4'd4, 32'hFFFFFFFF, 32'd10, 1'b1, "b2b_first");
      run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "b2b_second");
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         logic [3:0] op;
         logic [31:0] a, b;
         op = 4'($urandom_range(1, 6));
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
         if (op >= 4'd5) move_op(op, a);
         else run_op(op, a, b, 1'b1, "random");
      end
      check_hilo("random_end");
   endtask

   task automatic test_reset_abort();
      MDOp = 4'd4; A = 32'd100; B = 32'd7; Req = 1'b0;
      @(posedge clk); #1;
      MDOp = 4'd0;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (Busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_busy_before: got %b want 1", Busy);
      end
      reset = 1'b0;
      #1;
      hi_m = 32'd0; lo_m = 32'd0;
      checks++;
      if (Busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_busy_now: got %b want 0", Busy);
      end
      check_hilo("abort_now");
      @(negedge clk);
      reset = 1'b1;
      repeat (15) @(negedge clk);
      checks++;
      if (Busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_busy_after: got %b want 0", Busy);
      end
      check_hilo("abort_after");
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_move();
      test_ignored();
      test_back_to_back();
      test_random();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage. Owns the HI/LO registers.
- Executes mult, multu, div, divu, mthi and mtlo.
- Exports Start and Busy to the hazard controller. That controller stalls D whenever an MDU-class instruction sits in D while Start or Busy is high.
- HI/LO feed the E/M/W forwarding paths as the HI and LO write-data sources.

Parameters:
- MULT_CYCLES, 5, Busy duration for mult/multu (range 1..15).
- DIV_CYCLES, 10, Busy duration for div/divu (range 1..15).

Ports:
- clk  input  1  Pipeline clock. All state updates on the rising edge.
- reset  input  1  Asynchronous, active-low reset (low = reset asserted).
- MDOp  input  4  E-stage operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7-15 treated as none.
- Req  input  1  Exception/interrupt request for the E-stage instruction. When high, MDOp is ignored this cycle.
- A  input  32  Forwarded rs operand (ALU A after MFALUAE mux).
- B  input  32  Forwarded rt operand (ALU B after MFALUBE mux).
- Start  output  1  Combinational. High when MDOp is 1-4, Req=0 and Busy=0.
- Busy  output  1  Registered. High while an operation is in flight.
- HI  output  32  Registered HI.
- LO  output  32  Registered LO.

Behaviour:
- Reset (reset low, asynchronous, effective immediately):
  - HI=0, LO=0, Busy=0, counter=0.
  - Latched result and pending-op state cleared.
  - Reset asserted mid-operation aborts it: HI/LO are not updated afterwards.
- States:
  - IDLE: counter==0, Busy=0.
  - RUN: counter>0, Busy=1.
- IDLE to RUN, on the edge where Start=1:
  - counter loaded with MULT_CYCLES (op 1/2) or DIV_CYCLES (op 3/4).
  - Full result computed from A/B and held in internal 64-bit {rhi,rlo}. Later changes to A/B have no effect.
- RUN, each edge: counter decrements. On the edge where counter goes 1 to 0: HI<=rhi, LO<=rlo, Busy goes 0.
- Latency:
  - Start at edge k gives Busy=1 in cycles k+1..k+N (N = MULT_CYCLES or DIV_CYCLES).
  - New HI/LO are visible from the cycle after edge k+N, i.e. the same cycle Busy reads 0.
- Arithmetic:
  - mult: {HI,LO} = signed(A)*signed(B), 64-bit.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = signed quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
  - divu: LO = unsigned quotient, HI = unsigned remainder.
  - div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (B==0, div or divu): still runs DIV_CYCLES with Busy high; on completion HI and LO keep their prior values.
- mthi/mtlo:
  - Taken only when Busy=0 and Req=0.
  - Write HI (or LO) <= A on the next edge.
  - Busy and Start stay 0.
- Ignored inputs:
  - Any MDOp while Busy=1 is ignored; no restart, no HI/LO write. The hazard controller prevents this case and the block stays safe regardless.
  - Req=1 ignores MDOp entirely; Start=0.
  - Req arriving while Busy=1 does not cancel the in-flight operation, because its instruction has already left E and is committed.
- Simultaneous events: the completion edge and a new MDOp on the same edge cannot occur, because Busy=1 during that cycle blocks MDOp. Back-to-back operations therefore have at least one idle cycle between the Busy periods.

Test Plan:
- mult A=0xFFFFFFFE (-2), B=3, Req=0:
  - Start=1 in cycle 0; Busy=1 cycles 1-5.
  - From cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - multu with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (-7), B=2:
  - Busy=1 cycles 1-10.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7, B=2 gives LO=3, HI=1.
- Prior HI=0x11, LO=0x22, then div A=5, B=0: Busy for 10 cycles, then HI=0x11, LO=0x22 unchanged.
- mthi A=0xDEADBEEF, then next cycle mtlo A=0x1234:
  - HI=0xDEADBEEF, LO=0x1234.
  - Busy and Start never rise.
- During a mult in flight:
  - MDOp=mtlo with A=0x55 in cycle 3 is ignored; the final LO is the product.
  - MDOp=mult with Req=1 gives Start=0, Busy stays 0, and HI/LO are unchanged.
- Reset abort: start divu, drive reset low in cycle 4. HI=LO=0 and Busy=0 immediately (before the next clk edge). After reset is released, no completion write occurs.
